// File: rtl/call_ret_ctrl.sv
// Return-address stack sequencer: turns CALL/RET requests into stack push/pop
// strobes and PC-load commands, tracking occupancy and sticky overflow/underflow.
module call_ret_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic [ADDR_W-1:0] ret_addr,
  input  logic [ADDR_W-1:0] call_target,
  input  logic              flush,
  input  logic              clr_fault,
  output logic              ack,
  output logic              err,
  output logic              busy,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_value,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [ADDR_W-1:0] stk_wdata,
  input  logic [ADDR_W-1:0] stk_rdata,
  output logic              stk_rst,
  output logic [CW-1:0]     depth,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CALL = 3'd1;
  localparam logic [2:0] S_POP  = 3'd2;
  localparam logic [2:0] S_RET  = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [CW-1:0] DEPTH_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] ONE       = CW'(1);

  logic [2:0]        state_r, state_s;
  logic [CW-1:0]     depth_r, depth_s;
  logic [ADDR_W-1:0] wdata_r, target_r;
  logic              capture_s, ovf_set_s, unf_set_s;
  logic              ovf_r, unf_r, stk_rst_r, rst_pend_r;

  // Next-state, occupancy and fault-set decode; flush overrides everything
  always_comb begin
    state_s   = state_r;
    depth_s   = depth_r;
    capture_s = 1'b0;
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;
    if (flush) begin
      state_s = S_IDLE;
      depth_s = '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (call_req) begin
            if (depth_r < DEPTH_MAX) begin
              capture_s = 1'b1;
              depth_s   = depth_r + ONE;
              state_s   = S_CALL;
            end else begin
              ovf_set_s = 1'b1;
              state_s   = S_ERR;
            end
          end else if (ret_req) begin
            if (depth_r != '0) begin
              depth_s = depth_r - ONE;
              state_s = S_POP;
            end else begin
              unf_set_s = 1'b1;
              state_s   = S_ERR;
            end
          end else begin
            state_s = S_IDLE;
          end
        end
        S_CALL:  state_s = S_IDLE;
        S_POP:   state_s = S_RET;
        S_RET:   state_s = S_IDLE;
        S_ERR:   state_s = S_IDLE;
        default: state_s = S_IDLE;
      endcase
    end
  end

  // State, captured operands, fault flags and stack reset pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      depth_r    <= '0;
      wdata_r    <= '0;
      target_r   <= '0;
      ovf_r      <= 1'b0;
      unf_r      <= 1'b0;
      stk_rst_r  <= 1'b1;
      rst_pend_r <= 1'b1;
    end else begin
      state_r    <= state_s;
      depth_r    <= depth_s;
      // rst_pend_r stretches stk_rst one cycle past reset release
      stk_rst_r  <= flush | rst_pend_r;
      rst_pend_r <= 1'b0;
      if (capture_s) begin
        wdata_r  <= ret_addr;
        target_r <= call_target;
      end else begin
        wdata_r  <= wdata_r;
        target_r <= target_r;
      end
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (clr_fault) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
      if (unf_set_s) begin
        unf_r <= 1'b1;
      end else if (clr_fault) begin
        unf_r <= 1'b0;
      end else begin
        unf_r <= unf_r;
      end
    end
  end

  // Moore output decode; RET passes the stack's registered data straight through
  always_comb begin
    ack      = 1'b0;
    err      = 1'b0;
    pc_load  = 1'b0;
    pc_value = '0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    case (state_r)
      S_IDLE: begin
        ack = 1'b0;
      end
      S_CALL: begin
        stk_push = 1'b1;
        pc_load  = 1'b1;
        pc_value = target_r;
        ack      = 1'b1;
      end
      S_POP: begin
        stk_pop = 1'b1;
      end
      S_RET: begin
        pc_load  = 1'b1;
        pc_value = stk_rdata;
        ack      = 1'b1;
      end
      S_ERR: begin
        ack = 1'b1;
        err = 1'b1;
      end
      default: begin
        ack = 1'b0;
      end
    endcase
  end

  assign busy      = (state_r != S_IDLE);
  assign stk_wdata = wdata_r;
  assign stk_rst   = stk_rst_r;
  assign depth     = depth_r;
  assign overflow  = ovf_r;
  assign underflow = unf_r;

endmodule

// File: tb/tb_call_ret_ctrl.sv
// Directed bench for call_ret_ctrl with a small LIFO model standing in for the stack.
module tb_call_ret_ctrl;

  logic       clk = 1'b0;
  logic       rst, call_req, ret_req, flush, clr_fault;
  logic [7:0] ret_addr, call_target, stk_rdata;
  logic       ack, err, busy, pc_load, stk_push, stk_pop, stk_rst, overflow, underflow;
  logic [7:0] pc_value, stk_wdata;
  logic [1:0] depth;
  int         checks = 0;
  int         errors = 0;

  logic [7:0] mem [0:3];
  logic [1:0] ptr;
  wire  [5:0] strobes = {ack, err, pc_load, stk_push, stk_pop, busy};

  always #5 clk = ~clk;

  call_ret_ctrl #(.ADDR_W(8), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .call_req(call_req), .ret_req(ret_req),
    .ret_addr(ret_addr), .call_target(call_target), .flush(flush),
    .clr_fault(clr_fault), .ack(ack), .err(err), .busy(busy),
    .pc_load(pc_load), .pc_value(pc_value), .stk_push(stk_push),
    .stk_pop(stk_pop), .stk_wdata(stk_wdata), .stk_rdata(stk_rdata),
    .stk_rst(stk_rst), .depth(depth), .overflow(overflow), .underflow(underflow)
  );

  // Pointer-based LIFO with registered data_out and active-high reset
  always @(posedge clk) begin
    if (stk_rst) begin
      ptr       <= 2'd0;
      stk_rdata <= 8'h00;
    end else if (stk_push) begin
      mem[ptr] <= stk_wdata;
      ptr      <= ptr + 2'd1;
    end else if (stk_pop) begin
      stk_rdata <= mem[ptr - 2'd1];
      ptr       <= ptr - 2'd1;
    end
  end

  task automatic test_reset();
    rst = 1'b0; call_req = 1'b0; ret_req = 1'b0; flush = 1'b0; clr_fault = 1'b0;
    ret_addr = 8'h00; call_target = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (strobes !== 6'b000000) begin errors++; $display("FAIL reset_strobes: got %b expected %b", strobes, 6'b000000); end
      checks++; if ({stk_rst, depth, overflow, underflow} !== 5'b10000) begin errors++; $display("FAIL reset_flags: got %b expected %b", {stk_rst, depth, overflow, underflow}, 5'b10000); end
    end
    checks++; if ({pc_value, stk_wdata} !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected %h", {pc_value, stk_wdata}, 16'h0000); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (stk_rst !== 1'b1) begin errors++; $display("FAIL reset_stk_rst_extra: got %b expected %b", stk_rst, 1'b1); end
    checks++; if (strobes !== 6'b000000) begin errors++; $display("FAIL reset_idle: got %b expected %b", strobes, 6'b000000); end
    @(negedge clk);
    checks++; if (stk_rst !== 1'b0) begin errors++; $display("FAIL reset_stk_rst_end: got %b expected %b", stk_rst, 1'b0); end
  endtask

  task automatic test_call_ret();
    call_req = 1'b1; ret_addr = 8'h11; call_target = 8'h40;
    @(negedge clk);
    checks++; if (strobes !== 6'b101101) begin errors++; $display("FAIL cr_call_strobes: got %b expected %b", strobes, 6'b101101); end
    checks++; if ({pc_value, stk_wdata, depth} !== {8'h40, 8'h11, 2'd1}) begin errors++; $display("FAIL cr_call_data: got %h/%h/%0d expected 40/11/1", pc_value, stk_wdata, depth); end
    call_req = 1'b0;
    @(negedge clk);
    checks++; if (strobes !== 6'b000000) begin errors++; $display("FAIL cr_idle: got %b expected %b", strobes, 6'b000000); end
    ret_req = 1'b1;
    @(negedge clk);
    checks++; if ({strobes, depth} !== {6'b000011, 2'd0}) begin errors++; $display("FAIL cr_pop: got %b/%0d expected 000011/0", strobes, depth); end
    @(negedge clk);
    checks++; if (strobes !== 6'b101001) begin errors++; $display("FAIL cr_ret_strobes: got %b expected %b", strobes, 6'b101001); end
    checks++; if ({pc_value, depth} !== {8'h11, 2'd0}) begin errors++; $display("FAIL cr_ret_data: got %h/%0d expected 11/0", pc_value, depth); end
    ret_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back_overflow();
    call_req = 1'b1; ret_addr = 8'h01; call_target = 8'h80;
    @(negedge clk);
    checks++; if ({strobes, stk_wdata, depth} !== {6'b101101, 8'h01, 2'd1}) begin errors++; $display("FAIL ov_call1: got %b/%h/%0d expected 101101/01/1", strobes, stk_wdata, depth); end
    ret_addr = 8'h02; call_target = 8'h81;
    @(negedge clk);
    checks++; if (strobes !== 6'b000000) begin errors++; $display("FAIL ov_gap1: got %b expected %b", strobes, 6'b000000); end
    @(negedge clk);
    checks++; if ({strobes, pc_value, stk_wdata, depth} !== {6'b101101, 8'h81, 8'h02, 2'd2}) begin errors++; $display("FAIL ov_call2: got %b/%h/%h/%0d expected 101101/81/02/2", strobes, pc_value, stk_wdata, depth); end
    ret_addr = 8'h03; call_target = 8'h82;
    @(negedge clk);
    @(negedge clk);
    checks++; if (strobes !== 6'b110001) begin errors++; $display("FAIL ov_err_strobes: got %b expected %b", strobes, 6'b110001); end
    checks++; if ({overflow, depth, stk_wdata, pc_value} !== {1'b1, 2'd2, 8'h02, 8'h00}) begin errors++; $display("FAIL ov_err_state: got %b/%0d/%h/%h expected 1/2/02/00", overflow, depth, stk_wdata, pc_value); end
    call_req = 1'b0;
    @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ov_sticky: got %b expected %b", overflow, 1'b1); end
    ret_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({strobes, pc_value, depth} !== {6'b101001, 8'h02, 2'd1}) begin errors++; $display("FAIL ov_ret1: got %b/%h/%0d expected 101001/02/1", strobes, pc_value, depth); end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++; if ({strobes, pc_value, depth} !== {6'b101001, 8'h01, 2'd0}) begin errors++; $display("FAIL ov_ret2: got %b/%h/%0d expected 101001/01/0", strobes, pc_value, depth); end
    ret_req = 1'b0; clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ov_clear: got %b expected %b", overflow, 1'b0); end
  endtask

  task automatic test_underflow();
    ret_req = 1'b1;
    @(negedge clk);
    checks++; if ({strobes, underflow, depth} !== {6'b110001, 1'b1, 2'd0}) begin errors++; $display("FAIL un_err: got %b/%b/%0d expected 110001/1/0", strobes, underflow, depth); end
    ret_req = 1'b0; clr_fault = 1'b1;
    @(negedge clk);
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL un_clear: got %b expected %b", underflow, 1'b0); end
    ret_req = 1'b1;
    @(negedge clk);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL un_set_wins: got %b expected %b", underflow, 1'b1); end
    ret_req = 1'b0; clr_fault = 1'b0;
    @(negedge clk);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL un_sticky: got %b expected %b", underflow, 1'b1); end
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL un_clear2: got %b expected %b", underflow, 1'b0); end
  endtask

  task automatic test_simultaneous();
    call_req = 1'b1; ret_req = 1'b1; ret_addr = 8'h5A; call_target = 8'hC0;
    @(negedge clk);
    checks++; if ({strobes, pc_value, depth} !== {6'b101101, 8'hC0, 2'd1}) begin errors++; $display("FAIL sim_call: got %b/%h/%0d expected 101101/c0/1", strobes, pc_value, depth); end
    call_req = 1'b0;
    @(negedge clk);
    checks++; if (strobes !== 6'b000000) begin errors++; $display("FAIL sim_idle: got %b expected %b", strobes, 6'b000000); end
    @(negedge clk);
    checks++; if ({strobes, depth} !== {6'b000011, 2'd0}) begin errors++; $display("FAIL sim_pop: got %b/%0d expected 000011/0", strobes, depth); end
    @(negedge clk);
    checks++; if ({strobes, pc_value} !== {6'b101001, 8'h5A}) begin errors++; $display("FAIL sim_ret: got %b/%h expected 101001/5a", strobes, pc_value); end
    ret_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flush();
    call_req = 1'b1; ret_addr = 8'h33; call_target = 8'h44;
    @(negedge clk);
    call_req = 1'b0;
    @(negedge clk);
    ret_req = 1'b1;
    @(negedge clk);
    checks++; if (strobes !== 6'b000011) begin errors++; $display("FAIL fl_pop: got %b expected %b", strobes, 6'b000011); end
    flush = 1'b1;
    @(negedge clk);
    checks++; if ({strobes, depth, stk_rst} !== {6'b000000, 2'd0, 1'b1}) begin errors++; $display("FAIL fl_abort: got %b/%0d/%b expected 000000/0/1", strobes, depth, stk_rst); end
    flush = 1'b0; ret_req = 1'b0;
    @(negedge clk);
    checks++; if ({strobes, stk_rst} !== {6'b000000, 1'b0}) begin errors++; $display("FAIL fl_pulse_end: got %b/%b expected 000000/0", strobes, stk_rst); end
    ret_req = 1'b1;
    @(negedge clk);
    checks++; if ({strobes, underflow} !== {6'b110001, 1'b1}) begin errors++; $display("FAIL fl_underflow: got %b/%b expected 110001/1", strobes, underflow); end
    ret_req = 1'b0; clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    call_req = 1'b1; ret_addr = 8'h77; call_target = 8'h78;
    @(negedge clk);
    checks++; if (depth !== 2'd1) begin errors++; $display("FAIL fl_call_depth: got %0d expected %0d", depth, 2'd1); end
    call_req = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if ({strobes, depth, stk_rst, underflow} !== {6'b000000, 2'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL fl_depth_clear: got %b/%0d/%b/%b expected 000000/0/1/0", strobes, depth, stk_rst, underflow); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_call_ret();
    test_back_to_back_overflow();
    test_underflow();
    test_simultaneous();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
